univ_shift_reg: RTL and testbench



---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_burst_cnt.sv | 30 +++
 rtl/univ_shift_reg.sv | 130 +++++++++++++
 tb/tb_univ_shift_reg.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared constants and types for the universal shift register.
// Mode codes, FSM state type and shift direction encodings.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ROL  = 3'b101;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } usr_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/usr_burst_cnt.sv
// Loadable down-counter for the burst serialiser.
// Never wraps: decrement is ignored once the count is zero.
module usr_burst_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             is_last
);

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         cnt <= '0;
      end else if (en) begin
         if (load) begin
            cnt <= load_val;
         end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign is_last = (cnt == CNT_W'(1));

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with mode select, rotate and burst serialiser.
// Define USR_PARITY_EN to get a registered even-parity output on par.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic             burst_dir,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done,
   output logic             par
);

   usr_state_t       state;
   usr_state_t       state_nx;
   logic [WIDTH-1:0] q_nx;
   logic             dir_reg;
   logic             dir_nx;
   logic             done_nx;
   logic             cnt_load;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt;
   logic             is_last;

   usr_burst_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk     (clk),
      .clear   (clear),
      .en      (en),
      .load    (cnt_load),
      .dec     (cnt_dec),
      .load_val(CNT_W'(WIDTH)),
      .cnt     (cnt),
      .is_last (is_last)
   );

   always_comb begin
      q_nx     = q;
      state_nx = state;
      dir_nx   = dir_reg;
      done_nx  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (en) begin
         if (state == IDLE) begin
            if (start) begin
               q_nx     = d;
               dir_nx   = burst_dir;
               cnt_load = 1'b1;
               state_nx = SHIFT;
            end else begin
               case (mode)
                  MODE_SHR: begin
                     q_nx   = {sin_l, q[WIDTH-1:1]};
                     dir_nx = DIR_RIGHT;
                  end
                  MODE_SHL: begin
                     q_nx   = {q[WIDTH-2:0], sin_r};
                     dir_nx = DIR_LEFT;
                  end
                  MODE_LOAD: q_nx = d;
                  MODE_ROR: begin
                     q_nx   = {q[0], q[WIDTH-1:1]};
                     dir_nx = DIR_RIGHT;
                  end
                  MODE_ROL: begin
                     q_nx   = {q[WIDTH-2:0], q[WIDTH-1]};
                     dir_nx = DIR_LEFT;
                  end
                  default: q_nx = q;
               endcase
            end
         end else begin
            if (dir_reg == DIR_RIGHT) begin
               q_nx = {sin_l, q[WIDTH-1:1]};
            end else begin
               q_nx = {q[WIDTH-2:0], sin_r};
            end
            cnt_dec = 1'b1;
            if (is_last) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
      end
   end

   // done is cleared on every edge so it can never outlast one cycle
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         q       <= '0;
         state   <= IDLE;
         dir_reg <= DIR_LEFT;
         done    <= 1'b0;
      end else begin
         q       <= q_nx;
         state   <= state_nx;
         dir_reg <= dir_nx;
         done    <= done_nx;
      end
   end

`ifdef USR_PARITY_EN
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         par <= 1'b0;
      end else begin
         par <= ^q_nx;
      end
   end
`else
   assign par = 1'b0;
`endif

   assign busy = (state == SHIFT);
   assign sout = (dir_reg == DIR_RIGHT) ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed plus random bench for univ_shift_reg against a queue-based model.
// Parity expectations follow USR_PARITY_EN when the bench is built with it.
module tb_univ_shift_reg;

   localparam int W   = 8;
   localparam int MSB = 1 << (W - 1);
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         clear = 1'b1;
   logic         en = 1'b0;
   logic [2:0]   mode = 3'd0;
   logic [W-1:0] d = '0;
   logic         sin_l = 1'b0;
   logic         sin_r = 1'b0;
   logic         start = 1'b0;
   logic         burst_dir = 1'b0;
   logic [W-1:0] q;
   logic         sout;
   logic         busy;
   logic         done;
   logic         par;

   int vectors = 0;
   int miscompares = 0;

   int unsigned m_q;
   bit          m_dir;
   bit          m_busy;
   bit          m_done;
   int          m_left;
   bit          m_bits[$];

   always #5 clk = ~clk;

   univ_shift_reg #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .clear    (clear),
      .en       (en),
      .mode     (mode),
      .d        (d),
      .sin_l    (sin_l),
      .sin_r    (sin_r),
      .start    (start),
      .burst_dir(burst_dir),
      .q        (q),
      .sout     (sout),
      .busy     (busy),
      .done     (done),
      .par      (par)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q    = 0;
      m_dir  = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_bits.delete();
   endtask

   task automatic model_edge();
      m_done = 1'b0;
      if (clear) begin
         model_reset();
      end else if (en) begin
         if (m_busy) begin
            if (m_dir) m_q = (m_q >> 1) + (sin_l ? MSB : 0);
            else       m_q = ((m_q * 2) % MOD) + (sin_r ? 1 : 0);
            void'(m_bits.pop_front());
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (start) begin
            m_q    = d;
            m_dir  = burst_dir;
            m_busy = 1'b1;
            m_left = W;
            m_bits.delete();
            for (int i = 0; i < W; i++)
               m_bits.push_back(burst_dir ? d[i] : d[W-1-i]);
         end else begin
            case (mode)
               3'd1: begin
                  m_q   = (m_q >> 1) + (sin_l ? MSB : 0);
                  m_dir = 1'b1;
               end
               3'd2: begin
                  m_q   = ((m_q * 2) % MOD) + (sin_r ? 1 : 0);
                  m_dir = 1'b0;
               end
               3'd3: m_q = d;
               3'd4: begin
                  m_q   = (m_q >> 1) + ((m_q % 2) * MSB);
                  m_dir = 1'b1;
               end
               3'd5: begin
                  m_q   = ((m_q * 2) % MOD) + (m_q / MSB);
                  m_dir = 1'b0;
               end
               default: ;
            endcase
         end
      end
   endtask

   function automatic bit exp_par();
`ifdef USR_PARITY_EN
      return ^m_q;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_all();
      bit es;
      if (m_busy)     es = m_bits[0];
      else if (m_dir) es = bit'(m_q % 2);
      else            es = bit'(m_q / MSB);
      chk("q", q, m_q);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("sout", sout, es);
      chk("par", par, exp_par());
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      bit [W-1:0] got;
      int         bcyc;
      int         dones;
      int         k;

      model_reset();
      #2;
      check_all();
      #10;
      clear = 1'b0;

      en = 1'b1; mode = 3'd3; d = 8'hA5;
      step();
      chk("load_a5", q, 8'hA5);
      mode = 3'd0; start = 1'b1; d = 8'h5C;
      step();
      start = 1'b0;
      step();
      step();
      clear = 1'b1;
      #1;
      model_reset();
      chk("async_q", q, 8'h00);
      chk("async_busy", busy, 1'b0);
      chk("async_done", done, 1'b0);
      #1;
      clear = 1'b0;
      repeat (10) step();

      mode = 3'd3; d = 8'h3C;
      step();
      chk("load_3c", q, 8'h3C);
      mode = 3'd2; sin_r = 1'b1;
      step();
      chk("shl_1", q, 8'h79);
      step();
      chk("shl_2", q, 8'hF3);
      chk("shl_sout", sout, 1'b1);

      mode = 3'd3; d = 8'h81;
      step();
      mode = 3'd4;
      repeat (8) step();
      chk("ror_x8", q, 8'h81);
      mode = 3'd5;
      step();
      chk("rol_1", q, 8'h03);

      mode = 3'd0; start = 1'b1; d = 8'hB2; burst_dir = 1'b0;
      step();
      start = 1'b0;
      got = '0; bcyc = 0; dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) begin
            got = {got[W-2:0], sout};
            bcyc++;
         end
         step();
         if (done) dones++;
      end
      chk("burst_bits", got, 8'hB2);
      chk("burst_busy_cyc", bcyc, 8);
      chk("burst_dones", dones, 1);

      start = 1'b1; d = 8'hB2; burst_dir = 1'b0;
      step();
      start = 1'b0;
      got = '0; bcyc = 0; dones = 0;
      for (int i = 0; i < 24; i++) begin
         en    = !(i >= 3 && i < 6);
         start = (i == 4 || i == 7);
         if (busy) begin
            bcyc++;
            if (en) got = {got[W-2:0], sout};
         end
         step();
         if (done) dones++;
      end
      en = 1'b1; start = 1'b0;
      chk("stall_bits", got, 8'hB2);
      chk("stall_busy_cyc", bcyc, 11);
      chk("stall_dones", dones, 1);
      chk("stall_no_restart", busy, 1'b0);

      start = 1'b1; d = 8'h5A; burst_dir = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         step();
         k++;
      end
      chk("b2b_done_seen", done, 1'b1);
      start = 1'b1; d = 8'hC3; burst_dir = 1'b0;
      step();
      start = 1'b0;
      chk("b2b_busy", busy, 1'b1);
      repeat (10) step();

      mode = 3'd3; d = 8'h07;
      step();
      chk("par_07", par, exp_par());
      mode = 3'd2; sin_r = 1'b0;
      step();
      chk("par_0e_q", q, 8'h0E);
      chk("par_0e", par, exp_par());

      repeat (400) begin
         en        = ($urandom_range(0, 3) != 0);
         mode      = 3'($urandom_range(0, 7));
         d         = W'($urandom);
         sin_l     = 1'($urandom);
         sin_r     = 1'($urandom);
         start     = ($urandom_range(0, 7) == 0);
         burst_dir = 1'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
